// File: rtl/data_mem_unit.sv
// Byte-addressable data memory with a fixed-latency access sequencer and pipeline stall output.
// Optional macro DMEM_MISALIGN_TRAP_EN rejects misaligned requests instead of force-aligning them.
module data_mem_unit #(
   parameter int DATA_W     = 32,
   parameter int DM_ADDRESS = 9,
   parameter int LATENCY    = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic [2:0]            funct3,
   input  logic [DM_ADDRESS-1:0] addr,
   input  logic [DATA_W-1:0]     wr_data,
   output logic [DATA_W-1:0]     rd_data,
   output logic                  busy,
   output logic                  done,
   output logic                  misalign
);

   // state | meaning
   // IDLE  | waiting for a request; busy follows the request combinationally
   // WAIT  | counting down the access latency; access performed when cnt hits 0
   // DONE  | one-cycle completion pulse; the still-present request is ignored
   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   localparam int DEPTH = 1 << DM_ADDRESS;

   state_t                  state, state_nx;
   logic [3:0]              cnt;
   logic                    op_wr;
   logic [2:0]              f3_q;
   logic [DM_ADDRESS-1:0]   addr_q;
   logic [DATA_W-1:0]       wdata_q;
   logic [7:0]              mem [DEPTH];

   logic                    req, rejected, accept;
   logic [DM_ADDRESS-1:0]   addr_al;
   logic [DM_ADDRESS-1:0]   a1, a2, a3;
   logic [7:0]              b0, b1, b2, b3;
   logic [DATA_W-1:0]       load_val;

   assign req = mem_read | mem_write;

`ifdef DMEM_MISALIGN_TRAP_EN
   logic mis_req;
   always_comb begin
      case (funct3[1:0])
         2'b00:   mis_req = 1'b0;
         2'b01:   mis_req = addr[0];
         default: mis_req = (addr[1:0] != 2'b00);
      endcase
   end
   assign rejected = (state == IDLE) & req & mis_req;
   assign misalign = rejected;
`else
   assign rejected = 1'b0;
   assign misalign = 1'b0;
`endif

   // Low address bits are cleared to the access size so every access stays naturally aligned.
   always_comb begin
      case (funct3[1:0])
         2'b00:   addr_al = addr;
         2'b01:   addr_al = {addr[DM_ADDRESS-1:1], 1'b0};
         default: addr_al = {addr[DM_ADDRESS-1:2], 2'b00};
      endcase
   end

   assign accept = (state == IDLE) & req & ~rejected;

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      case (state)
         IDLE: begin
            busy = accept;
            if (accept) state_nx = WAIT;
         end
         WAIT: begin
            busy = 1'b1;
            if (cnt == 4'd0) state_nx = DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign done = (state == DONE);

   assign a1 = addr_q + DM_ADDRESS'(1);
   assign a2 = addr_q + DM_ADDRESS'(2);
   assign a3 = addr_q + DM_ADDRESS'(3);
   assign b0 = mem[addr_q];
   assign b1 = mem[a1];
   assign b2 = mem[a2];
   assign b3 = mem[a3];

   always_comb begin
      case (f3_q)
         3'b000:  load_val = {{24{b0[7]}}, b0};
         3'b001:  load_val = {{16{b1[7]}}, b1, b0};
         3'b100:  load_val = {24'd0, b0};
         3'b101:  load_val = {16'd0, b1, b0};
         default: load_val = {b3, b2, b1, b0};
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         rd_data <= '0;
         op_wr   <= 1'b0;
         f3_q    <= 3'd0;
         addr_q  <= '0;
         wdata_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= 8'd0;
      end else begin
         state <= state_nx;
         if (accept) begin
            op_wr   <= mem_write;
            f3_q    <= funct3;
            addr_q  <= addr_al;
            wdata_q <= wr_data;
            cnt     <= 4'(LATENCY - 1);
         end
         if (state == WAIT) begin
            if (cnt != 4'd0) begin
               cnt <= cnt - 4'd1;
            end else if (op_wr) begin
               mem[addr_q] <= wdata_q[7:0];
               if (f3_q[1:0] != 2'b00) mem[a1] <= wdata_q[15:8];
               if (f3_q[1]) begin
                  mem[a2] <= wdata_q[23:16];
                  mem[a3] <= wdata_q[31:24];
               end
            end else begin
               rd_data <= load_val;
            end
         end
      end
   end

endmodule

// File: tb/tb_data_mem_unit.sv
// Self-checking bench for data_mem_unit: directed scenarios plus random accesses against a byte-array model.
module tb_data_mem_unit;
   localparam int L = 2;

   logic        clock = 1'b0;
   logic        reset;
   logic        mem_read, mem_write;
   logic [2:0]  funct3;
   logic [8:0]  addr;
   logic [31:0] wr_data;
   logic [31:0] rd_data;
   logic        busy, done, misalign;

   int errors = 0;
   int checks = 0;

   logic [7:0]  mem_m [512];
   logic [31:0] exp_rd;

   always #5 clock = ~clock;

   data_mem_unit #(.DATA_W(32), .DM_ADDRESS(9), .LATENCY(L)) dut (
      .clock(clock), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
      .funct3(funct3), .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
      .busy(busy), .done(done), .misalign(misalign)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 512; i++) mem_m[i] = 8'd0;
      exp_rd = 32'd0;
   endtask

   task automatic clear_inputs();
      mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'd0; addr = 9'd0; wr_data = 32'd0;
   endtask

   task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [8:0] a, input logic [31:0] d);
      int          nbytes;
      logic        mis;
      logic [8:0]  ea;
      logic [31:0] v, mask;
      nbytes = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      mis    = (a % nbytes) != 0;
      ea     = 9'(a - (a % nbytes));
      @(posedge clock); #1;
      mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wr_data = d;
`ifdef DMEM_MISALIGN_TRAP_EN
      if (mis) begin
         @(negedge clock);
         check("rej_misalign", misalign, 1);
         check("rej_busy", busy, 0);
         @(posedge clock); #1;
         clear_inputs();
         @(negedge clock);
         check("rej_done", done, 0);
         check("rej_rd_data", rd_data, exp_rd);
         return;
      end
`else
      if (mis) ; // unaligned addresses are silently aligned by ea
`endif
      if (wr) begin
         for (int k = 0; k < nbytes; k++) mem_m[9'(ea + k)] = d[8*k +: 8];
      end else begin
         v = 32'd0;
         for (int k = 0; k < nbytes; k++) v = v | (32'(mem_m[9'(ea + k)]) << (8*k));
         mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*nbytes)) - 32'd1);
         if (!f3[2] && nbytes < 4 && v[8*nbytes-1]) v = v | ~mask;
         exp_rd = v;
      end
      for (int c = 0; c <= L; c++) begin
         @(negedge clock);
         check("busy_inflight", busy, 1);
         check("done_early", done, 0);
      end
      @(negedge clock);
      check("busy_at_done", busy, 0);
      check("done_pulse", done, 1);
      check("misalign_off", misalign, 0);
      check("rd_data", rd_data, exp_rd);
      @(posedge clock); #1;
      clear_inputs();
      @(negedge clock);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("idle_rd_data", rd_data, exp_rd);
   endtask

   initial begin
      logic r, w;
      clear_inputs();
      reset = 1'b1;
      model_clear();
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_rd_data", rd_data, 0);
      check("rst_misalign", misalign, 0);
      @(posedge clock); #1;
      reset = 1'b0;

      access(0, 1, 3'b010, 9'h10, 32'hDEADBEEF);
      access(1, 0, 3'b010, 9'h10, 32'h0);
      check("lw10", rd_data, 32'hDEADBEEF);
      access(1, 0, 3'b000, 9'h13, 32'h0);
      check("lb13", rd_data, 32'hFFFFFFDE);
      access(1, 0, 3'b100, 9'h13, 32'h0);
      check("lbu13", rd_data, 32'h000000DE);
      access(1, 0, 3'b001, 9'h10, 32'h0);
      check("lh10", rd_data, 32'hFFFFBEEF);
      access(1, 0, 3'b101, 9'h12, 32'h0);
      check("lhu12", rd_data, 32'h0000DEAD);
      access(0, 1, 3'b000, 9'h11, 32'h00000055);
      access(1, 0, 3'b010, 9'h10, 32'h0);
      check("lw10_after_sb", rd_data, 32'hDEAD55EF);
      access(1, 0, 3'b010, 9'h12, 32'h0);
      check("lw12_misaligned", rd_data, 32'hDEAD55EF);

      // reset while a store is in WAIT
      @(posedge clock); #1;
      mem_write = 1'b1; funct3 = 3'b010; addr = 9'h20; wr_data = 32'h12345678;
      @(negedge clock);
      check("rst_wait_busy0", busy, 1);
      @(posedge clock); #1;
      reset = 1'b1;
      @(negedge clock);
      check("rst_wait_busy1", busy, 1);
      @(posedge clock); #1;
      reset = 1'b0;
      clear_inputs();
      @(negedge clock);
      check("post_rst_busy", busy, 0);
      check("post_rst_done", done, 0);
      check("post_rst_rd", rd_data, 0);
      model_clear();
      access(1, 0, 3'b010, 9'h20, 32'h0);
      check("lw20_discarded", rd_data, 32'h0);
      access(1, 0, 3'b010, 9'h10, 32'h0);
      check("lw10_cleared", rd_data, 32'h0);

      access(1, 0, 3'b010, 9'h10, 32'h0);
      access(0, 1, 3'b011, 9'h04, 32'h0BAD_F00D);
      access(1, 0, 3'b010, 9'h04, 32'h0);
      access(1, 1, 3'b010, 9'h30, 32'hA5A5A5A5);
      check("both_rd_unchanged", rd_data, 32'h0BAD_F00D);
      access(1, 0, 3'b010, 9'h30, 32'h0);
      check("lw30", rd_data, 32'hA5A5A5A5);

      for (int n = 0; n < 60; n++) begin
         r = 1'($urandom_range(0, 1));
         w = 1'($urandom_range(0, 1));
         if (!r && !w) r = 1'b1;
         access(r, w, 3'($urandom_range(0, 7)), 9'($urandom_range(0, 63)), $urandom);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/data_mem_unit.md
# data_mem_unit

Byte-addressable data memory with a multi-cycle access sequencer, sitting directly downstream of the pipeline datapath's MEM stage: it consumes the EX/MEM register's ALU result (address), store data, funct3 and MemRead/MemWrite controls. It returns load data to the MEM/WB register and drives a `busy` stall request so the pipeline freezes while an access is in flight. Loads and stores are RV32I-sized (byte/half/word), and loads are sign- or zero-extended.

## Interface
Parameters:
- `DATA_W`, 32, data width; only 32 is supported.
- `DM_ADDRESS`, 9, byte-address width; memory holds 2^DM_ADDRESS bytes.
- `LATENCY`, 2, wait cycles per access; legal range 1..15.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `mem_read`  in  1  load request (EX/MEM MemRead).
- `mem_write`  in  1  store request (EX/MEM MemWrite); wins if both are high.
- `funct3`  in  3  access size/sign (RV32I load/store encoding).
- `addr`  in  DM_ADDRESS  byte address (EX/MEM ALU result, low bits).
- `wr_data`  in  DATA_W  store data (forwarded rs2).
- `rd_data`  out  DATA_W  extended load result; registered.
- `busy`  out  1  stall request to the pipeline.
- `done`  out  1  one-cycle pulse when an access completes.
- `misalign`  out  1  misaligned request flag.

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - `busy` = (mem_read|mem_write) & ~rejected, combinational.
  - On an accepted request, capture op, addr, wr_data and funct3, load `cnt` with LATENCY-1, and go to WAIT.
- WAIT:
  - `busy`=1.
  - When `cnt`≠0, decrement it.
  - When `cnt`==0, perform the access at this edge and go to DONE.
  - A store updates only the addressed bytes, little-endian.
  - A load writes the extended value into `rd_data`.
- DONE:
  - `busy`=0, `done`=1.
  - Inputs are ignored: the pipeline still presents the same request this cycle.
  - Unconditionally return to IDLE.
- Sizes by funct3:
  - 000: LB/SB, sign-extended on load.
  - 001: LH/SH, sign-extended on load.
  - 010: LW/SW.
  - 100: LBU, zero-extended.
  - 101: LHU, zero-extended.
  - 011, 110, 111: word access.
  - Stores use the size bits only.
- Alignment:
  - Half-word is misaligned if addr[0]=1.
  - Word is misaligned if addr[1:0]≠0.
  - Byte accesses are never misaligned.
- `rd_data` holds its value until the next completed load; stores do not change it.
- The address cannot leave the array: its width equals DM_ADDRESS.

## Timing
- Reset values: state IDLE, `cnt`=0, `rd_data`=0, `done`=0, `misalign`=0; all memory bytes are cleared to 0.
- `busy`=0 whenever the FSM is in IDLE with no request.
- Request first presented in cycle 0:
  - `busy` is high in cycles 0..LATENCY.
  - The access happens at the end of cycle LATENCY.
  - `done` and valid `rd_data` appear in cycle LATENCY+1, with `busy`=0.
- Back-to-back requests: the earliest next acceptance is cycle LATENCY+2, the IDLE cycle after DONE.
- Reset in any cycle overrides everything: FSM returns to IDLE, a pending store is discarded, and memory clears.
- Simultaneous `mem_read` and `mem_write` is treated as a store.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined:
  - A misaligned request in IDLE is rejected: `misalign`=1 (combinational), `busy`=0, the FSM stays IDLE, and neither memory nor `rd_data` is touched.
- Not defined:
  - `misalign` is tied 0.
  - Captured address low bits are forced aligned (addr[0] cleared for half, addr[1:0] cleared for word).
  - The access proceeds normally.

## Test plan
- Reset, then LATENCY=2, SW 0xDEADBEEF at addr 0x10, then LW at 0x10: `busy` high for 3 cycles each, `done` in cycle 3, `rd_data`=0xDEADBEEF.
- After the store above: LB at 0x13 → 0xFFFFFFDE; LBU at 0x13 → 0x000000DE; LH at 0x10 → 0xFFFFBEEF; LHU at 0x12 → 0x0000DEAD.
- SB 0x55 at 0x11, then LW at 0x10 → 0xDEAD55EF; other bytes unchanged.
- LW at 0x12:
  - With DMEM_MISALIGN_TRAP_EN: `misalign`=1, `busy`=0, the FSM stays IDLE, and `rd_data` keeps its prior value.
  - Without it: the access reads 0x10 and returns 0xDEAD55EF after the normal latency.
- Assert `reset` in the WAIT cycle of an SW 0x12345678 at 0x20: the FSM goes to IDLE next cycle, `busy`=0, and a later LW at 0x20 returns 0.
- Simultaneous `mem_read`=`mem_write`=1 with SW 0xA5A5A5A5 at 0x30: `rd_data` is unchanged at `done`, and a following LW at 0x30 returns 0xA5A5A5A5.
